// File: rtl/dmem_arbiter.sv
// Two-port arbiter (CPU priority, DMA anti-starvation) for a single-port data RAM with a 1-cycle registered read.
// Optional grant statistics are compiled in with `define DMEM_ARB_STATS_EN.
`timescale 1ns/1ps

module dmem_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4   // 1..15
) (
    input  logic              Clk,
    input  logic              Reset,

    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dma_req,
    input  logic              dma_wr,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy,
    output logic              grant_dma,
    output logic [15:0]       stats_cpu,
    output logic [15:0]       stats_dma
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [1:0]        state_q,      state_d;
    logic              grant_dma_q,  grant_dma_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic              mem_wr_q,     mem_wr_d;
    logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;

    logic grant_go;
    logic grant_to_dma;
    logic starved;

    assign starved = (starve_cnt_q == STARVE_MAX);

    // Grant decision: from IDLE both ports compete; from ACK only the non-owner may be handed the RAM.
    always_comb begin
        state_d      = state_q;
        grant_go     = 1'b0;
        grant_to_dma = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req || dma_req) begin
                    grant_go     = 1'b1;
                    grant_to_dma = dma_req && (!cpu_req || starved);
                end
            end
            ST_ISSUE: begin
                state_d = ST_ACK;
            end
            ST_ACK: begin
                if (grant_dma_q ? cpu_req : dma_req) begin
                    grant_go     = 1'b1;
                    grant_to_dma = !grant_dma_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (grant_go) begin
            state_d = ST_ISSUE;
        end
    end

    always_comb begin
        grant_dma_d = grant_dma_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wr_d    = 1'b0;
        if (grant_go) begin
            grant_dma_d = grant_to_dma;
            mem_addr_d  = grant_to_dma ? dma_addr  : cpu_addr;
            mem_wdata_d = grant_to_dma ? dma_wdata : cpu_wdata;
            mem_wr_d    = grant_to_dma ? dma_wr    : cpu_wr;
        end
    end

    // Counts CPU wins while the DMA is asking; any DMA win resets it.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_go && grant_to_dma) begin
            starve_cnt_d = 4'd0;
        end else if (grant_go && dma_req && (starve_cnt_q < STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            grant_dma_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wr_q     <= 1'b0;
            mem_wdata_q  <= '0;
            starve_cnt_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            grant_dma_q  <= grant_dma_d;
            mem_addr_q   <= mem_addr_d;
            mem_wr_q     <= mem_wr_d;
            mem_wdata_q  <= mem_wdata_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign grant_dma = grant_dma_q;

    // Read data comes straight from the RAM; it is only meaningful while the matching ack is high.
    assign cpu_ack   = (state_q == ST_ACK) && !grant_dma_q;
    assign dma_ack   = (state_q == ST_ACK) &&  grant_dma_q;
    assign cpu_rdata = mem_rdata;
    assign dma_rdata = mem_rdata;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stats_cpu_q;
    logic [15:0] stats_dma_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stats_cpu_q <= 16'h0000;
            stats_dma_q <= 16'h0000;
        end else begin
            if (grant_go && !grant_to_dma && (stats_cpu_q != 16'hFFFF)) begin
                stats_cpu_q <= stats_cpu_q + 16'h0001;
            end
            if (grant_go && grant_to_dma && (stats_dma_q != 16'hFFFF)) begin
                stats_dma_q <= stats_dma_q + 16'h0001;
            end
        end
    end

    assign stats_cpu = stats_cpu_q;
    assign stats_dma = stats_dma_q;
`else
    assign stats_cpu = 16'h0000;
    assign stats_dma = 16'h0000;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: drivers queue expected acks, a negedge monitor pops and compares them.
`timescale 1ns/1ps

module tb_dmem_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        cpu_req, cpu_wr, dma_req, dma_wr;
    logic [7:0]  cpu_addr, dma_addr;
    logic [15:0] cpu_wdata, dma_wdata;
    logic        cpu_ack, dma_ack;
    logic [15:0] cpu_rdata, dma_rdata;
    logic [7:0]  mem_addr;
    logic        mem_wr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy, grant_dma;
    logic [15:0] stats_cpu, stats_dma;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        bit          chk_data;
        logic [15:0] rdata;
        int          ack_cyc;
    } exp_t;

    exp_t cpu_q[$];
    exp_t dma_q[$];

    dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .STARVE_LIMIT(4)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .cpu_req   (cpu_req),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .dma_req   (dma_req),
        .dma_wr    (dma_wr),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_ack   (dma_ack),
        .dma_rdata (dma_rdata),
        .mem_addr  (mem_addr),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .grant_dma (grant_dma),
        .stats_cpu (stats_cpu),
        .stats_dma (stats_dma)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // 256x16 RAM with registered read
    logic [15:0] ram [0:255];
    always @(posedge Clk) begin
        if (mem_wr) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every ack must match the oldest queued expectation for that port.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (cpu_ack) begin
                if (cpu_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL cpu_ack_unexpected: got ack expected none (cycle %0d)", cyc);
                end else begin
                    e = cpu_q.pop_front();
                    chk("cpu_ack_cycle", cyc, e.ack_cyc);
                    if (e.chk_data) chk("cpu_rdata", int'(cpu_rdata), int'(e.rdata));
                end
            end
            if (dma_ack) begin
                if (dma_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL dma_ack_unexpected: got ack expected none (cycle %0d)", cyc);
                end else begin
                    e = dma_q.pop_front();
                    chk("dma_ack_cycle", cyc, e.ack_cyc);
                    if (e.chk_data) chk("dma_rdata", int'(dma_rdata), int'(e.rdata));
                end
            end
        end
    end

    // Called just after a rising edge; ack_off is the hand-computed ack cycle relative to now.
    task automatic cpu_access(input logic wr, input logic [7:0] a, input logic [15:0] d,
                              input logic [15:0] exp_d, input int ack_off);
        exp_t e;
        int n;
        e.chk_data = !wr; e.rdata = exp_d; e.ack_cyc = cyc + ack_off;
        cpu_q.push_back(e);
        cpu_req = 1'b1; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
        n = 0;
        do begin @(negedge Clk); n++; end while (!cpu_ack && n < 20);
        if (!cpu_ack) begin
            checks++; failures++;
            $display("FAIL cpu_timeout: got no ack expected ack within 20 cycles");
        end
        @(posedge Clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic dma_access(input logic wr, input logic [7:0] a, input logic [15:0] d,
                              input logic [15:0] exp_d, input int ack_off);
        exp_t e;
        int n;
        e.chk_data = !wr; e.rdata = exp_d; e.ack_cyc = cyc + ack_off;
        dma_q.push_back(e);
        dma_req = 1'b1; dma_wr = wr; dma_addr = a; dma_wdata = d;
        n = 0;
        do begin @(negedge Clk); n++; end while (!dma_ack && n < 20);
        if (!dma_ack) begin
            checks++; failures++;
            $display("FAIL dma_timeout: got no ack expected ack within 20 cycles");
        end
        @(posedge Clk); #1;
        dma_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        Reset = 1'b0;
        cpu_req = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_wr = 0; dma_addr = 0; dma_wdata = 0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_wr", int'(mem_wr), 0);
        chk("rst_mem_wdata", int'(mem_wdata), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_grant_dma", int'(grant_dma), 0);
        chk("rst_acks", int'({cpu_ack, dma_ack}), 0);
        chk("rst_stats", int'({stats_cpu, stats_dma}), 0);
        Reset = 1'b1;
        @(posedge Clk); #1;

        // Preload RAM through the DMA port (also exercises DMA writes)
        dma_access(1'b1, 8'h10, 16'hBEEF, 16'h0, 2);
        dma_access(1'b1, 8'h30, 16'h1111, 16'h0, 2);
        dma_access(1'b1, 8'h40, 16'h5A5A, 16'h0, 2);

        // Single CPU read: address at T+1, ack/data at T+2, busy for 2 cycles
        fork
            cpu_access(1'b0, 8'h10, 16'h0, 16'hBEEF, 2);
            begin
                @(posedge Clk); @(negedge Clk);
                chk("rd_mem_addr", int'(mem_addr), 8'h10);
                chk("rd_mem_wr", int'(mem_wr), 0);
                chk("rd_busy_t1", int'(busy), 1);
                chk("rd_grant_cpu", int'(grant_dma), 0);
                @(negedge Clk);
                chk("rd_busy_t2", int'(busy), 1);
                @(negedge Clk);
                chk("rd_busy_t3", int'(busy), 0);
            end
        join
        @(posedge Clk); #1;

        // CPU write: mem_wr for exactly one cycle, then read back
        fork
            cpu_access(1'b1, 8'h20, 16'h1234, 16'h0, 2);
            begin
                @(posedge Clk); @(negedge Clk);
                chk("wr_mem_wr_t1", int'(mem_wr), 1);
                chk("wr_mem_addr", int'(mem_addr), 8'h20);
                chk("wr_mem_wdata", int'(mem_wdata), 16'h1234);
                @(negedge Clk);
                chk("wr_mem_wr_t2", int'(mem_wr), 0);
            end
        join
        @(posedge Clk); #1;
        cpu_access(1'b0, 8'h20, 16'h0, 16'h1234, 2);

        // Simultaneous requests: CPU first, DMA issued from the CPU ack cycle
        fork
            cpu_access(1'b0, 8'h10, 16'h0, 16'hBEEF, 2);
            dma_access(1'b0, 8'h40, 16'h0, 16'h5A5A, 4);
            begin
                @(posedge Clk); @(negedge Clk);
                chk("both_first_cpu", int'(grant_dma), 0);
                @(negedge Clk); @(negedge Clk);
                chk("both_then_dma", int'(grant_dma), 1);
            end
        join
        @(posedge Clk); #1;

        // Starvation: four CPU wins while dma_req is seen, then DMA is forced
        for (int i = 0; i < 4; i++) begin
            e.chk_data = 1'b1; e.rdata = 16'h1234; e.ack_cyc = cyc + 2;
            cpu_q.push_back(e);
            cpu_req = 1; cpu_wr = 0; cpu_addr = 8'h20;
            dma_req = 1; dma_wr = 0; dma_addr = 8'h40;
            @(posedge Clk); #1;
            chk("starve_cpu_wins", int'(grant_dma), 0);
            dma_req = 0;
            @(posedge Clk); #1;
            @(posedge Clk); #1;
        end
        e.chk_data = 1'b1; e.rdata = 16'h5A5A; e.ack_cyc = cyc + 2;
        dma_q.push_back(e);
        e.chk_data = 1'b1; e.rdata = 16'h1234; e.ack_cyc = cyc + 4;
        cpu_q.push_back(e);
        cpu_req = 1; dma_req = 1;
        @(posedge Clk); #1;
        chk("starve_dma_forced", int'(grant_dma), 1);
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        dma_req = 0;
        chk("starve_cpu_after_dma", int'(grant_dma), 0);
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        cpu_req = 0;
        @(posedge Clk); #1;
        // Counter was cleared by the forced DMA grant: CPU wins again
        fork
            cpu_access(1'b0, 8'h10, 16'h0, 16'hBEEF, 2);
            dma_access(1'b0, 8'h40, 16'h0, 16'h5A5A, 4);
            begin
                @(posedge Clk); @(negedge Clk);
                chk("starve_cleared_cpu", int'(grant_dma), 0);
            end
        join
        @(posedge Clk); #1;

        // Reset during ISSUE of a write: write suppressed, no ack
        cpu_req = 1; cpu_wr = 1; cpu_addr = 8'h30; cpu_wdata = 16'hAAAA;
        @(posedge Clk); @(negedge Clk);
        chk("rstw_mem_wr_before", int'(mem_wr), 1);
        Reset = 1'b0;
        #1;
        chk("rstw_mem_wr", int'(mem_wr), 0);
        chk("rstw_busy", int'(busy), 0);
        chk("rstw_mem_addr", int'(mem_addr), 0);
        chk("rstw_mem_wdata", int'(mem_wdata), 0);
        chk("rstw_grant", int'(grant_dma), 0);
        chk("rstw_acks", int'({cpu_ack, dma_ack}), 0);
        chk("rstw_stats", int'({stats_cpu, stats_dma}), 0);
        cpu_req = 0; cpu_wr = 0;
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk); #1;
        cpu_access(1'b0, 8'h30, 16'h0, 16'h1111, 2);

        // Grant statistics: 3 CPU and 2 DMA accesses since reset
        cpu_access(1'b0, 8'h10, 16'h0, 16'hBEEF, 2);
        cpu_access(1'b0, 8'h20, 16'h0, 16'h1234, 2);
        dma_access(1'b0, 8'h40, 16'h0, 16'h5A5A, 2);
        dma_access(1'b0, 8'h10, 16'h0, 16'hBEEF, 2);
        @(negedge Clk);
`ifdef DMEM_ARB_STATS_EN
        chk("stats_cpu", int'(stats_cpu), 3);
        chk("stats_dma", int'(stats_dma), 2);
`else
        chk("stats_cpu", int'(stats_cpu), 0);
        chk("stats_dma", int'(stats_dma), 0);
`endif

        repeat (3) @(negedge Clk);
        chk("cpu_q_drained", cpu_q.size(), 0);
        chk("dma_q_drained", dma_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
